mips32_prog_loader: RTL
=======================

// Module: mips32_prog_loader
// PURPOSE
//  Hardware program loader for the pipelined MIPS32 core. Receives a framed byte
//  stream and writes big-endian 32-bit words into instruction memory from BASE_ADDR.
//  Holds the core halted during loading. On a verified frame, pulses cpu_start to
//  clear pc, HALTED and TAKEN_BRANCH.
//  Frame: SYNC_BYTE, LEN (words, 1..255), 4*LEN data bytes (MSB first), CSUM
//  (XOR of all data bytes).
// PARAMETERS
//  ADDR_W     10      instruction-memory word-address width
//  BASE_ADDR  0       first word address written
//  SYNC_BYTE  8'hA5   frame start marker
// PORTS
//  clk1       in   1       single clock; all state updates on rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       byte available on in_data
//  in_data    in   8       stream byte
//  in_ready   out  1       loader accepts byte (transfer = in_valid & in_ready)
//  mem_we     out  1       instruction-memory write strobe, one cycle per word
//  mem_addr   out  ADDR_W  word address for mem_we
//  mem_wdata  out  32      word for mem_we
//  cpu_hold   out  1       1 = core must stay halted
//  cpu_start  out  1       one-cycle pulse: pc<=0, HALTED<=0, TAKEN_BRANCH<=0
//  done       out  1       sticky: last frame loaded and verified
//  err        out  1       sticky: last frame rejected
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0,
//    cpu_hold=1, cpu_start=0, done=0, err=0, byte/word counters=0, csum=0.
//  - Reset asserted mid-frame aborts the frame; words already written stay in memory.
//  - All outputs are registered.
//  - States:
//    - IDLE: accepted byte == SYNC_BYTE -> LEN, clear done, err, csum; else discard.
//    - LEN: byte 0 -> ERROR. LEN > 2^ADDR_W - BASE_ADDR -> ERROR.
//      Otherwise latch word count, mem_addr=BASE_ADDR, cpu_hold=1 -> DATA.
//    - DATA: shift bytes into a 32-bit word, MSB first, and XOR each into csum.
//      On the 4th byte, mem_we=1 on the next cycle with the assembled word and the
//      current mem_addr; mem_addr increments after the strobe.
//      After the last word -> CSUM.
//    - CSUM: byte == csum -> START; else -> ERROR.
//    - START: in_ready=0 for one cycle; cpu_start=1, cpu_hold=0, done=1 -> IDLE.
//    - ERROR: err=1, cpu_hold stays 1, -> IDLE. err clears on the next SYNC_BYTE.
//  - in_ready=1 in every state except START. Gaps in in_valid stall the FSM with
//    no state change.
//  - Latency: last data byte accepted -> mem_we one cycle later.
//    CSUM byte accepted -> cpu_start one cycle later.
//  - SYNC_BYTE inside DATA is treated as data; there is no resync mid-frame.
//  - mem_addr never wraps, because the LEN bound is checked first.
//  - cpu_hold stays 0 after a good load until the next SYNC_BYTE re-asserts it.
// STRUCTURE
//  - Shared package mips32_pkg: loader state encoding, SYNC_BYTE default, and the
//    HLT opcode 6'h3f that benches use to terminate programs.
//  - One sub-module, mips32_word_packer: byte shift register, 2-bit byte count,
//    word_valid pulse and running XOR. The FSM, address counter and CPU control
//    stay in the top module.
// TESTING
//  - Single word: A5 01 28 01 00 0A 23 -> mem_we@addr0 data 32'h2801000a;
//    cpu_start pulse 1 cycle after 23; cpu_hold 1->0; done=1.
//  - Full ALU program: 9 words (2801000a..fc000000) with correct XOR.
//    Run the core 20 cycles. Expected: R1=10, R2=20, R3=25, R4=30, R5=55.
//  - Bad checksum: A5 01 28 01 00 0A 24 -> err=1, no cpu_start, cpu_hold=1,
//    word at addr0 written.
//  - Length errors:
//    - LEN=00 -> err=1, no mem_we.
//    - ADDR_W=2, LEN=05 -> err=1.
//  - Backpressure/noise: 3 idle cycles between bytes, junk bytes 00 FF before A5
//    -> same result as the single-word case.
//  - Reset mid-DATA, after 2 of 4 bytes: mem_we=0, cpu_hold=1, state IDLE.
//    A following good frame loads correctly.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 program loader: loader state encoding,
// default frame marker and the HLT opcode used to terminate loaded programs.
package mips32_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_CSUM  = 3'd3;
    localparam logic [2:0] ST_START = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [5:0] OP_HLT        = 6'h3f;

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input, instruction-memory write port and core control of the loader.
interface mips32_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic              done;
    logic              err;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, done, err
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, done, err
    );
endinterface

// File: rtl/mips32_word_packer.sv
// Assembles data bytes MSB-first into 32-bit words and keeps the running XOR
// checksum of every byte accepted since the last clear.
module mips32_word_packer (
    input  logic        clk1,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [7:0]  csum,
    output logic        last_byte
);

    logic [23:0] shift;
    logic [1:0]  cnt;

    assign last_byte = (cnt == 2'd3);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            shift      <= '0;
            cnt        <= '0;
            csum       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shift <= '0;
                cnt   <= '0;
                csum  <= '0;
            end else if (shift_en) begin
                csum <= csum ^ byte_in;
                cnt  <= cnt + 2'd1;
                if (last_byte) begin
                    word       <= {shift, byte_in};
                    word_valid <= 1'b1;
                end else begin
                    shift <= {shift[15:0], byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader: writes big-endian words into instruction memory,
// holds the core while loading and releases it with cpu_start on a verified frame.
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic clk1,
    input  logic rst,
    mips32_prog_loader_if.master bus
);

    localparam int unsigned       MAX_WORDS = (2 ** ADDR_W) - BASE_ADDR;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    logic [2:0] state;
    logic [7:0] word_cnt;
    logic       accept;
    logic       data_byte;
    logic       clear;
    logic       last_byte;
    logic [7:0] csum;
    logic       len_bad;

    assign accept    = bus.in_valid & bus.in_ready;
    assign data_byte = accept && (state == ST_DATA);
    assign clear     = accept && (state == ST_IDLE) && (bus.in_data == SYNC_BYTE);
    assign len_bad   = (bus.in_data == 8'd0) || (32'(bus.in_data) > MAX_WORDS);

    mips32_word_packer u_packer (
        .clk1       (clk1),
        .rst        (rst),
        .clear      (clear),
        .shift_en   (data_byte),
        .byte_in    (bus.in_data),
        .word       (bus.mem_wdata),
        .word_valid (bus.mem_we),
        .csum       (csum),
        .last_byte  (last_byte)
    );

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            word_cnt      <= '0;
            bus.in_ready  <= 1'b1;
            bus.mem_addr  <= BASE;
            bus.cpu_hold  <= 1'b1;
            bus.cpu_start <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.cpu_start <= 1'b0;
            // The final word's strobe happens in CSUM, so the address never steps past the frame.
            if (bus.mem_we && state == ST_DATA)
                bus.mem_addr <= bus.mem_addr + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state        <= ST_LEN;
                        bus.done     <= 1'b0;
                        bus.err      <= 1'b0;
                        bus.cpu_hold <= 1'b1;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            state <= ST_ERROR;
                        end else begin
                            word_cnt     <= bus.in_data;
                            bus.mem_addr <= BASE;
                            bus.cpu_hold <= 1'b1;
                            state        <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (data_byte && last_byte) begin
                        word_cnt <= word_cnt - 8'd1;
                        if (word_cnt == 8'd1)
                            state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (bus.in_data == csum) begin
                            state         <= ST_START;
                            bus.in_ready  <= 1'b0;
                            bus.cpu_start <= 1'b1;
                            bus.cpu_hold  <= 1'b0;
                            bus.done      <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                        end
                    end
                end
                ST_START: begin
                    bus.in_ready <= 1'b1;
                    state        <= ST_IDLE;
                end
                ST_ERROR: begin
                    bus.err <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
